// File: rtl/dm_ctrl.sv
// MEM-stage data-memory access unit: byte-lane store alignment, load extraction, fault flagging.
// Optional DM_MISALIGN_SPLIT_EN: misaligned word/half accesses become two word accesses.
module dm_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_dmtype,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE1, S_ISSUE2, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_we;
    logic [ADDR_W-1:0]  r_waddr;
    logic [1:0]         r_off;
    logic [31:0]        r_wdata;
    logic [2:0]         r_dmtype;
    logic               r_err;
    logic               r_split;

    logic               w_accept;
    logic               w_illegal;
    logic               w_mis;
    logic               w_err;
    logic               w_split;
    logic [7:0]         w_mask8;
    logic [63:0]        w_wdata64;
    logic [31:0]        w_ld_lo;
    logic [63:0]        w_ld_cat;
    logic               w_unused;

    function automatic logic [3:0] size_mask(input logic [2:0] t);
        case (t)
            3'd0:       return 4'b1111;
            3'd1, 3'd2: return 4'b0011;
            default:    return 4'b0001;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [2:0] t);
        case (t)
            3'd1:    return {{16{d[15]}}, d[15:0]};
            3'd2:    return {16'h0000, d[15:0]};
            3'd3:    return {{24{d[7]}}, d[7:0]};
            3'd4:    return {24'h000000, d[7:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] t, input logic [1:0] off);
        return ((t == 3'd0) && (off != 2'd0)) ||
               (((t == 3'd1) || (t == 3'd2)) && (off == 2'd3));
    endfunction

    assign w_accept  = req_valid && (r_state == S_IDLE);
    assign w_illegal = (req_dmtype > 3'd4);
    assign w_mis     = misaligned(req_dmtype, req_addr[1:0]);

`ifdef DM_MISALIGN_SPLIT_EN
    logic [31:0] r_hold;

    assign w_err   = w_illegal;
    assign w_split = w_mis && !w_illegal;

    // Word A arrives during ISSUE2; word A+1 arrives during DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= 32'h0;
        end else if (r_state == S_ISSUE2) begin
            r_hold <= mem_rdata;
        end
    end

    assign w_ld_lo = r_split ? r_hold : mem_rdata;
`else
    assign w_err   = w_illegal || w_mis;
    assign w_split = 1'b0;
    assign w_ld_lo = mem_rdata;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_off    <= 2'd0;
            r_wdata  <= 32'h0;
            r_dmtype <= 3'd0;
            r_err    <= 1'b0;
            r_split  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we     <= req_we;
                r_waddr  <= req_addr[ADDR_W+1:2];
                r_off    <= req_addr[1:0];
                r_wdata  <= req_wdata;
                r_dmtype <= req_dmtype;
                r_err    <= w_err;
                r_split  <= w_split;
            end
        end
    end

    // Upper half of the shifted mask/data is the overflow into word A+1.
    assign w_mask8   = {4'b0000, size_mask(r_dmtype)} << r_off;
    assign w_wdata64 = {32'h0, r_wdata} << {r_off, 3'b000};
    assign w_ld_cat  = {mem_rdata, w_ld_lo} >> {r_off, 3'b000};

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 4'b0000;
        mem_addr   = '0;
        mem_wdata  = 32'h0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'h0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = S_ISSUE1;
            end
            S_ISSUE1: begin
                if (!r_err) begin
                    mem_en   = 1'b1;
                    mem_addr = r_waddr;
                    if (r_we) begin
                        mem_we    = w_mask8[3:0];
                        mem_wdata = w_wdata64[31:0];
                    end
                end
                w_next = r_split ? S_ISSUE2 : S_DONE;
            end
            S_ISSUE2: begin
                mem_en   = 1'b1;
                mem_addr = r_waddr + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (r_we) begin
                    mem_we    = w_mask8[7:4];
                    mem_wdata = w_wdata64[63:32];
                end
                w_next = S_DONE;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                if (!r_err && !r_we) resp_rdata = load_ext(w_ld_cat[31:0], r_dmtype);
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_unused = &{1'b0, req_addr[31:ADDR_W+2], w_ld_cat[63:32], 1'b0};

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl with a synchronous byte-enabled SRAM model.
// Expectations follow DM_MISALIGN_SPLIT_EN when that macro is defined.
module tb_dm_ctrl;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [31:0]       req_addr = 32'h0;
    logic [31:0]       req_wdata = 32'h0;
    logic [2:0]        req_dmtype = 3'd0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;

    logic [31:0] sram [0:(1<<ADDR_W)-1];
    bit          loaded = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    dm_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_dmtype (req_dmtype),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < (1<<ADDR_W); i++) sram[i] <= 32'h0;
            sram[0] <= 32'h80017F00;
            sram[1] <= 32'h44332211;
            sram[2] <= 32'h88776655;
            loaded  <= 1'b1;
        end else if (mem_en) begin
            for (int i = 0; i < 4; i++)
                if (mem_we[i]) sram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            if (mem_we == 4'b0000) mem_rdata <= sram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    endtask

    // Returns at the falling edge of cycle T+1 (ISSUE1).
    task automatic start(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] t);
        @(negedge clk);
        chk("ready_before_req", {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = a;
        req_wdata  = d;
        req_dmtype = t;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    task automatic chk_resp(input string tag, input logic err, input logic [31:0] data);
        chk({tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
        chk({tag, "_err"},   {31'h0, resp_err},   {31'h0, err});
        chk({tag, "_rdata"}, resp_rdata, data);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
        chk("rst_mem_we", {28'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", {22'h0, mem_addr}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;

        // sb 0x13
        start(1'b1, 32'h13, 32'h000000AB, 3'd3);
        chk("sb_en", {31'h0, mem_en}, 32'h1);
        chk("sb_addr", {22'h0, mem_addr}, 32'd4);
        chk("sb_we", {28'h0, mem_we}, 32'h8);
        chk("sb_wdata", mem_wdata, 32'hAB000000);
        chk("sb_busy", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        chk_resp("sb", 1'b0, 32'h0);
        chk("sb_sram", sram[4], 32'hAB000000);

        // lh / lhu / lbu / lb / lw aligned
        start(1'b0, 32'h2, 32'h0, 3'd1);
        chk("lh_en", {31'h0, mem_en}, 32'h1);
        chk("lh_we", {28'h0, mem_we}, 32'h0);
        chk("lh_addr", {22'h0, mem_addr}, 32'h0);
        @(negedge clk);
        chk_resp("lh", 1'b0, 32'hFFFF8001);
        start(1'b0, 32'h2, 32'h0, 3'd2);
        @(negedge clk);
        chk_resp("lhu", 1'b0, 32'h00008001);
        start(1'b0, 32'h1, 32'h0, 3'd4);
        @(negedge clk);
        chk_resp("lbu", 1'b0, 32'h0000007F);
        start(1'b0, 32'h3, 32'h0, 3'd3);
        @(negedge clk);
        chk_resp("lb", 1'b0, 32'hFFFFFF80);
        start(1'b0, 32'h4, 32'h0, 3'd0);
        @(negedge clk);
        chk_resp("lw_al", 1'b0, 32'h44332211);

        // Misaligned lw 0x6
        start(1'b0, 32'h6, 32'h0, 3'd0);
`ifdef DM_MISALIGN_SPLIT_EN
        chk("lwm_en1", {31'h0, mem_en}, 32'h1);
        chk("lwm_addr1", {22'h0, mem_addr}, 32'd1);
        @(negedge clk);
        chk("lwm_en2", {31'h0, mem_en}, 32'h1);
        chk("lwm_addr2", {22'h0, mem_addr}, 32'd2);
        chk("lwm_novalid", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        chk_resp("lwm", 1'b0, 32'h66554433);
`else
        chk("lwm_noen", {31'h0, mem_en}, 32'h0);
        @(negedge clk);
        chk_resp("lwm", 1'b1, 32'h0);
`endif

        // Misaligned sw 0xFFE with address wrap
        start(1'b1, 32'hFFE, 32'hDDCCBBAA, 3'd0);
`ifdef DM_MISALIGN_SPLIT_EN
        chk("swm_addr1", {22'h0, mem_addr}, 32'd1023);
        chk("swm_we1", {28'h0, mem_we}, 32'hC);
        chk("swm_data1", mem_wdata, 32'hBBAA0000);
        @(negedge clk);
        chk("swm_addr2", {22'h0, mem_addr}, 32'd0);
        chk("swm_we2", {28'h0, mem_we}, 32'h3);
        chk("swm_data2", mem_wdata, 32'h0000DDCC);
        @(negedge clk);
        chk_resp("swm", 1'b0, 32'h0);
`else
        chk("swm_noen", {31'h0, mem_en}, 32'h0);
        chk("swm_nowe", {28'h0, mem_we}, 32'h0);
        @(negedge clk);
        chk_resp("swm", 1'b1, 32'h0);
`endif

        // Illegal dmtype
        start(1'b0, 32'h8, 32'h0, 3'd6);
        chk("ill_noen", {31'h0, mem_en}, 32'h0);
        @(negedge clk);
        chk_resp("ill", 1'b1, 32'h0);

        // Back-to-back: req_valid held high across the busy window
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4; req_dmtype = 3'd0;
        @(negedge clk);
        chk("b2b_busy1", {31'h0, req_ready}, 32'h0);
        chk("b2b_addr1", {22'h0, mem_addr}, 32'd1);
        req_addr = 32'h8;
        @(negedge clk);
        chk("b2b_busy2", {31'h0, req_ready}, 32'h0);
        chk_resp("b2b_first", 1'b0, 32'h44332211);
        @(negedge clk);
        chk("b2b_idle", {31'h0, req_ready}, 32'h1);
        chk("b2b_idle_noen", {31'h0, mem_en}, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_addr2", {22'h0, mem_addr}, 32'd2);
        @(negedge clk);
        chk_resp("b2b_second", 1'b0, 32'h88776655);

        // Reset during ISSUE1 of a store
        start(1'b1, 32'h10, 32'h12345678, 3'd0);
        chk("rstm_en_before", {31'h0, mem_en}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("rstm_en_drop", {31'h0, mem_en}, 32'h0);
        chk("rstm_we_drop", {28'h0, mem_we}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        chk("rstm_novalid", {31'h0, resp_valid}, 32'h0);
        chk("rstm_ready", {31'h0, req_ready}, 32'h1);
        chk("rstm_sram_kept", sram[4], 32'hAB000000);
        @(negedge clk);
        chk("rstm_novalid2", {31'h0, resp_valid}, 32'h0);
        start(1'b0, 32'h4, 32'h0, 3'd0);
        @(negedge clk);
        chk_resp("rstm_lw", 1'b0, 32'h44332211);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
